// File: rtl/memory_island_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_island_pkg                                                    |
// | Shared types and helpers for memory-island port initiators.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package memory_island_pkg;

  // Command sequencer states of the stream initiator.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } msi_state_e;

  // Bits needed to count 0..depth inclusive (credit / occupancy counters).
  function automatic int unsigned credit_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_rsp_fifo                                                         |
// | Read-response FIFO; same-cycle push and pop allowed, even when full. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_rsp_fifo
  import memory_island_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 push_i,
  input  logic [DataWidth-1:0]                 data_i,
  input  logic                                 pop_i,
  output logic [DataWidth-1:0]                 data_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [credit_width(FifoDepth)-1:0]   count_o
);

  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntWidth = credit_width(FifoDepth);

  logic [DataWidth-1:0] storage [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;
  logic [CntWidth-1:0]  count;

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_next(wr_ptr);
      if (pop_i)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (push_i) storage[wr_ptr] <= data_i;
  end

  assign data_o  = storage[rd_ptr];
  assign empty_o = (count == '0);
  assign full_o  = (count == CntWidth'(FifoDepth));
  assign count_o = count;

endmodule
`default_nettype wire

// File: rtl/mem_stream_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stream_initiator                                                 |
// | Turns {addr, len, stride, write} commands into single-word requests  |
// | on a memory-island port; reads return through a credit-sized FIFO.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_stream_initiator
  import memory_island_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [LenWidth-1:0]    cmd_len_i,
  input  logic [AddrWidth-1:0]   cmd_stride_i,
  input  logic                   cmd_write_i,
  input  logic                   wdata_valid_i,
  output logic                   wdata_ready_o,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  output logic                   rdata_valid_o,
  input  logic                   rdata_ready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   mem_q_valid_o,
  input  logic                   mem_q_ready_i,
  output logic [AddrWidth-1:0]   mem_q_addr_o,
  output logic                   mem_q_write_o,
  output logic [DataWidth-1:0]   mem_q_data_o,
  output logic [DataWidth/8-1:0] mem_q_strb_o,
  input  logic                   mem_p_valid_i,
  input  logic [DataWidth-1:0]   mem_p_data_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = credit_width(FifoDepth);
  // Shared read/write in-flight counter: reads are credit-bounded, writes
  // are bounded only by the command length.
  localparam int unsigned OutWidth  = (CntWidth > LenWidth + 1) ? CntWidth : LenWidth + 1;
  localparam int unsigned SumWidth  = OutWidth + 1;
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);

  msi_state_e            state_q, state_d;
  logic [AddrWidth-1:0]  addr_q;
  logic [AddrWidth-1:0]  stride_q;
  logic [LenWidth-1:0]   remaining_q;
  logic                  write_q;
  logic [OutWidth-1:0]   outstanding_q;
  logic                  zero_done_q;

  logic                  cmd_hs;
  logic                  q_hs;
  logic                  issue_valid;
  logic                  credit_ok;
  logic                  rsp_accept;
  logic                  drain_done;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CntWidth-1:0]   fifo_count;
  logic [DataWidth-1:0]  fifo_data;

  assign cmd_hs     = cmd_valid_i & cmd_ready_o;
  // Responses with nothing in flight are stale (e.g. from before a reset).
  assign rsp_accept = mem_p_valid_i & (outstanding_q != '0);
  // Credit only shrinks through our own issue, so once valid it stays valid.
  assign credit_ok  = (SumWidth'(outstanding_q) + SumWidth'(fifo_count)) < SumWidth'(FifoDepth);
  assign issue_valid = (state_q == ST_ISSUE) & (write_q ? wdata_valid_i : credit_ok);
  assign q_hs       = issue_valid & mem_q_ready_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and port-side outputs.
  always_comb begin
    state_d       = state_q;
    cmd_ready_o   = 1'b0;
    busy_o        = 1'b0;
    wdata_ready_o = 1'b0;
    mem_q_addr_o  = '0;
    mem_q_write_o = 1'b0;
    mem_q_data_o  = '0;
    mem_q_strb_o  = '0;
    drain_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_hs && (cmd_len_i != '0)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy_o        = 1'b1;
        mem_q_addr_o  = addr_q & AlignMask;
        mem_q_write_o = write_q;
        if (write_q) begin
          wdata_ready_o = mem_q_ready_i;
          mem_q_data_o  = wdata_i;
          mem_q_strb_o  = wstrb_i;
        end
        if (q_hs && (remaining_q == LenWidth'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if ((outstanding_q == '0) && (write_q || fifo_empty)) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_q_valid_o = issue_valid;
  assign done_o        = zero_done_q | drain_done;

  // Command latch and address/remaining walk.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      write_q     <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= cmd_hs & (cmd_len_i == '0);
      if (cmd_hs) begin
        addr_q      <= cmd_addr_i;
        stride_q    <= cmd_stride_i;
        remaining_q <= cmd_len_i;
        write_q     <= cmd_write_i;
      end else if (q_hs) begin
        addr_q      <= addr_q + stride_q;
        remaining_q <= remaining_q - LenWidth'(1);
      end
    end
  end

  // In-flight request counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      case ({q_hs, rsp_accept})
        2'b10:   outstanding_q <= outstanding_q + OutWidth'(1);
        2'b01:   outstanding_q <= outstanding_q - OutWidth'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign fifo_push     = rsp_accept & ~write_q;
  assign fifo_pop      = rdata_valid_o & rdata_ready_i;
  assign rdata_valid_o = ~fifo_empty;
  assign rdata_o       = fifo_empty ? '0 : fifo_data;

  mem_rsp_fifo #(
    .DataWidth (DataWidth),
    .FifoDepth (FifoDepth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (mem_p_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifndef SYNTHESIS
  // A stalled request must keep its valid and fields until accepted.
  a_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_q_valid_o && !mem_q_ready_i) |=>
      (mem_q_valid_o && $stable(mem_q_addr_o) && $stable(mem_q_write_o)));

  // Credit accounting keeps the response FIFO from overflowing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (fifo_push && fifo_full) |-> fifo_pop);

  // Flag responses arriving with nothing in flight; they are dropped.
  always @(posedge clk_i) begin
    if (!rst_i && mem_p_valid_i && (outstanding_q == '0))
      $warning("mem_stream_initiator: response with no request in flight ignored");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stream_initiator                                              |
// | Scoreboard bench: stimulus queues expected requests/read data, a     |
// | memory model answers requests, monitors pop and compare.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_stream_initiator;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic [31:0] cmd_stride_i = '0;
  logic        cmd_write_i = 1'b0;
  logic        wdata_valid_i = 1'b0;
  logic        wdata_ready_o;
  logic [63:0] wdata_i = '0;
  logic [7:0]  wstrb_i = '0;
  logic        rdata_valid_o;
  logic        rdata_ready_i = 1'b1;
  logic [63:0] rdata_o;
  logic        mem_q_valid_o;
  logic        mem_q_ready_i = 1'b1;
  logic [31:0] mem_q_addr_o;
  logic        mem_q_write_o;
  logic [63:0] mem_q_data_o;
  logic [7:0]  mem_q_strb_o;
  logic        mem_p_valid_i = 1'b0;
  logic [63:0] mem_p_data_i = '0;
  logic        busy_o;
  logic        done_o;

  mem_stream_initiator dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .cmd_stride_i  (cmd_stride_i),
    .cmd_write_i   (cmd_write_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata_i),
    .wstrb_i       (wstrb_i),
    .rdata_valid_o (rdata_valid_o),
    .rdata_ready_i (rdata_ready_i),
    .rdata_o       (rdata_o),
    .mem_q_valid_o (mem_q_valid_o),
    .mem_q_ready_i (mem_q_ready_i),
    .mem_q_addr_o  (mem_q_addr_o),
    .mem_q_write_o (mem_q_write_o),
    .mem_q_data_o  (mem_q_data_o),
    .mem_q_strb_o  (mem_q_strb_o),
    .mem_p_valid_i (mem_p_valid_i),
    .mem_p_data_i  (mem_p_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 2;
  int hs_count = 0;
  int done_seen = 0;
  bit qr_toggle = 1'b0;
  bit qr_level = 1'b1;

  // Scoreboard queues (parallel per expected request).
  logic [31:0] exp_addr [$];
  logic        exp_wr   [$];
  logic [63:0] exp_wd   [$];
  logic [7:0]  exp_ws   [$];
  logic [63:0] exp_rdata [$];
  // Memory model pending responses.
  int          pend_due  [$];
  logic [63:0] pend_data [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_req(input logic [31:0] a, input logic w, input logic [63:0] d, input logic [7:0] s);
    exp_addr.push_back(a);
    exp_wr.push_back(w);
    exp_wd.push_back(d);
    exp_ws.push_back(s);
  endtask

  task automatic exp_rd(input logic [31:0] a);
    exp_req(a, 1'b0, 64'h0, 8'h0);
    exp_rdata.push_back({32'hCAFE_0000, a});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] l, input logic [31:0] s, input logic w);
    bit ok;
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_len_i = l; cmd_stride_i = s; cmd_write_i = w;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk_i);
      if (cmd_ready_o) ok = 1'b1;
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL cmd_accept: actual=timeout required=cmd_ready_o");
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    chk(name, {63'h0, seen}, 64'h1);
  endtask

  // Cycle counter, memory response driver and request-ready driver.
  initial forever begin
    @(posedge clk_i);
    cyc++;
    #1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_p_valid_i = 1'b1;
      mem_p_data_i  = pend_data.pop_front();
      void'(pend_due.pop_front());
    end else begin
      mem_p_valid_i = 1'b0;
      mem_p_data_i  = '0;
    end
    if (qr_toggle) mem_q_ready_i = ~mem_q_ready_i;
    else           mem_q_ready_i = qr_level;
  end

  // Request monitor: checks each accepted request and schedules its response.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;
  logic [7:0]  prev_strb;
  logic [31:0] m_a;
  logic        m_w;
  logic [63:0] m_d;
  logic [7:0]  m_s;
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("q_hold_valid", {63'h0, mem_q_valid_o}, 64'h1);
        chk("q_hold_addr", {32'h0, mem_q_addr_o}, {32'h0, prev_addr});
        chk("q_hold_data", mem_q_data_o, prev_data);
        chk("q_hold_strb", {56'h0, mem_q_strb_o}, {56'h0, prev_strb});
      end
      if (mem_q_valid_o && mem_q_ready_i) begin
        hs_count++;
        if (exp_addr.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_req: actual addr=%h required none", mem_q_addr_o);
        end else begin
          m_a = exp_addr.pop_front(); m_w = exp_wr.pop_front();
          m_d = exp_wd.pop_front();   m_s = exp_ws.pop_front();
          chk("req_addr", {32'h0, mem_q_addr_o}, {32'h0, m_a});
          chk("req_write", {63'h0, mem_q_write_o}, {63'h0, m_w});
          chk("req_data", mem_q_data_o, m_d);
          chk("req_strb", {56'h0, mem_q_strb_o}, {56'h0, m_s});
        end
        pend_due.push_back(cyc + lat);
        pend_data.push_back(mem_q_write_o ? 64'h0 : {32'hCAFE_0000, mem_q_addr_o});
      end
      prev_stall = mem_q_valid_o && !mem_q_ready_i;
      prev_addr  = mem_q_addr_o;
      prev_data  = mem_q_data_o;
      prev_strb  = mem_q_strb_o;
    end
  end

  // Read-data monitor.
  logic [63:0] r_e;
  initial forever begin
    @(negedge clk_i);
    if (rdata_valid_o && rdata_ready_i) begin
      if (exp_rdata.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_rdata: actual=%h required none", rdata_o);
      end else begin
        r_e = exp_rdata.pop_front();
        chk("rdata", rdata_o, r_e);
      end
    end
  end

  // done_o pulse counter.
  initial forever begin
    @(negedge clk_i);
    if (done_o) done_seen++;
  end

  // Write burst source data.
  logic [63:0] wd [3] = '{64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF};
  logic [7:0]  ws [3] = '{8'hFF, 8'h0F, 8'hA5};

  int h0, d0;
  bit wok;

  initial begin
    // Reset state.
    @(negedge clk_i); @(negedge clk_i); #1;
    chk("rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);
    chk("rst_busy", {63'h0, busy_o}, 64'h0);
    chk("rst_done", {63'h0, done_o}, 64'h0);
    chk("rst_q_valid", {63'h0, mem_q_valid_o}, 64'h0);
    chk("rst_rdata_valid", {63'h0, rdata_valid_o}, 64'h0);
    chk("rst_wdata_ready", {63'h0, wdata_ready_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(1);

    // 1: read 0x100 len 4 stride 8, latency 2, back-to-back issue.
    lat = 2; rdata_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) exp_rd(32'h100 + 32'(8 * i));
    h0 = hs_count; d0 = done_seen;
    send_cmd(32'h100, 16'd4, 32'd8, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("t1_back_to_back", 64'(hs_count - h0), 64'd4);
    wait_done("t1_done", 40);
    chk("t1_rdata_all_out", 64'(exp_rdata.size()), 64'd0);
    idle(3);
    chk("t1_done_once", 64'(done_seen - d0), 64'd1);

    // 2: read len 8 with consumer stalled: credit caps issue at 4.
    lat = 1; rdata_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) exp_rd(32'h200 + 32'(8 * i));
    h0 = hs_count; d0 = done_seen;
    send_cmd(32'h200, 16'd8, 32'd8, 1'b0);
    idle(12);
    chk("t2_credit_cap", 64'(hs_count - h0), 64'd4);
    chk("t2_q_valid_low", {63'h0, mem_q_valid_o}, 64'h0);
    chk("t2_rdata_valid", {63'h0, rdata_valid_o}, 64'h1);
    rdata_ready_i = 1'b1;
    wait_done("t2_done", 60);
    idle(3);
    chk("t2_all_issued", 64'(hs_count - h0), 64'd8);
    chk("t2_done_once", 64'(done_seen - d0), 64'd1);

    // 3: write 0x40 len 3 stride -8, request ready toggling.
    lat = 2; qr_toggle = 1'b1;
    exp_req(32'h40, 1'b1, wd[0], ws[0]);
    exp_req(32'h38, 1'b1, wd[1], ws[1]);
    exp_req(32'h30, 1'b1, wd[2], ws[2]);
    d0 = done_seen;
    send_cmd(32'h40, 16'd3, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wdata_valid_i = 1'b1; wdata_i = wd[i]; wstrb_i = ws[i];
      wok = 1'b0;
      for (int k = 0; k < 40 && !wok; k++) begin
        @(negedge clk_i);
        if (wdata_ready_o) wok = 1'b1;
      end
      chk("t3_wdata_accept", {63'h0, wok}, 64'h1);
      @(posedge clk_i); #1;
    end
    wdata_valid_i = 1'b0; wdata_i = '0; wstrb_i = '0;
    wait_done("t3_done", 40);
    chk("t3_rsp_before_done", 64'(pend_due.size()), 64'd0);
    qr_toggle = 1'b0; qr_level = 1'b1;
    idle(3);
    chk("t3_done_once", 64'(done_seen - d0), 64'd1);
    chk("t3_wdata_ready_idle", {63'h0, wdata_ready_o}, 64'h0);

    // 4: zero-length command.
    h0 = hs_count;
    send_cmd(32'h500, 16'd0, 32'd8, 1'b0);
    @(negedge clk_i); #1;
    chk("t4_done_pulse", {63'h0, done_o}, 64'h1);
    chk("t4_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);
    @(negedge clk_i); #1;
    chk("t4_done_single", {63'h0, done_o}, 64'h0);
    idle(3);
    chk("t4_no_request", 64'(hs_count - h0), 64'd0);
    chk("t4_not_busy", {63'h0, busy_o}, 64'h0);

    // 5: address wrap, then unaligned start address.
    lat = 1;
    exp_rd(32'hFFFF_FFF8);
    exp_rd(32'h0000_0000);
    send_cmd(32'hFFFF_FFF8, 16'd2, 32'd8, 1'b0);
    wait_done("t5_wrap_done", 40);
    idle(1);
    exp_rd(32'h100);
    send_cmd(32'h103, 16'd1, 32'd8, 1'b0);
    wait_done("t5_unaligned_done", 40);
    idle(1);

    // 6: reset mid-read after 2 of 4 issued.
    lat = 3;
    for (int i = 0; i < 4; i++) exp_rd(32'h700 + 32'(8 * i));
    h0 = hs_count;
    send_cmd(32'h700, 16'd4, 32'd8, 1'b0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1;
    exp_addr.delete(); exp_wr.delete(); exp_wd.delete(); exp_ws.delete();
    exp_rdata.delete(); pend_due.delete(); pend_data.delete();
    #1;
    chk("t6_issued_before_rst", 64'(hs_count - h0), 64'd2);
    chk("t6_rst_q_valid", {63'h0, mem_q_valid_o}, 64'h0);
    chk("t6_rst_busy", {63'h0, busy_o}, 64'h0);
    chk("t6_rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);
    chk("t6_rst_rdata_valid", {63'h0, rdata_valid_o}, 64'h0);
    chk("t6_rst_done", {63'h0, done_o}, 64'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    pend_due.push_back(cyc);
    pend_data.push_back(64'hDEAD_BEEF_DEAD_BEEF);
    repeat (4) begin
      @(negedge clk_i); #1;
      chk("t6_stray_ignored", {63'h0, rdata_valid_o}, 64'h0);
    end
    idle(1);
    lat = 2;
    exp_rd(32'h300);
    exp_rd(32'h310);
    d0 = done_seen;
    send_cmd(32'h300, 16'd2, 32'h10, 1'b0);
    wait_done("t6_fresh_done", 40);
    idle(3);
    chk("t6_done_once", 64'(done_seen - d0), 64'd1);

    chk("end_req_queue_empty", 64'(exp_addr.size()), 64'd0);
    chk("end_rdata_queue_empty", 64'(exp_rdata.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
